pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Program-counter sequencer for the core. It computes the `jump_en`/`abs_jump`/`target` controls for the program counter every cycle: sequential fetch, relative/absolute branches, subroutine call/return through a small return-address stack, stall, and halt. The program counter has no enable, so this block holds it by issuing a relative jump of 0. It sits between decode/hazard logic and the program counter.

## Interface
Parameters:
- D, 12, program-counter width
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high; same reset as the program counter
- start  input  1  begin or restart execution at address 0
- prog_ctr  input  D  current program counter value
- stall_req  input  1  hold the current address this cycle
- br_valid  input  1  taken branch this cycle
- br_abs  input  1  1 = absolute target, 0 = relative (two's complement, mod 2^D)
- br_target  input  D  branch/call target or offset
- call  input  1  subroutine call; target taken from br_abs/br_target
- ret  input  1  return to the address on top of the stack
- halt_req  input  1  stop execution
- jump_en  output  1  to the program counter
- abs_jump  output  1  to the program counter
- target  output  D  to the program counter
- running  output  1  state == RUN
- done  output  1  state == HALT
- ras_overflow  output  1  sticky; set on a call while the stack is full
- ras_underflow  output  1  sticky; set on a return while the stack is empty

## Operation
- States: IDLE (after reset), RUN, HALT.
- Hold encoding is jump_en=1, abs_jump=0, target=0. Sequential encoding is jump_en=0.
- IDLE/HALT:
  - With start=0, outputs are the hold encoding.
  - With start=1, outputs are jump_en=1, abs_jump=1, target=0. Next state is RUN. The stack and both sticky flags are cleared.
- RUN: the first matching rule applies, and all lower-priority inputs are ignored.
  1. halt_req: hold encoding; next state HALT.
  2. stall_req: hold encoding; no stack change.
  3. ret with the stack non-empty: pop, then abs_jump to the popped value.
  4. ret with the stack empty: set ras_underflow; hold encoding; next state HALT.
  5. call: push prog_ctr+1 (mod 2^D), then jump to br_target (absolute or relative per br_abs).
     - If the stack is full, the push is dropped, ras_overflow is set, and the jump is still taken.
  6. br_valid: jump_en=1, abs_jump=br_abs, target=br_target.
  7. Otherwise: sequential.
- Outputs are combinational from the state, the stack top, and the inputs. The stack, the state, and the flags update on the clock edge.
- start while in RUN is ignored.

## Timing
- Zero-cycle control latency: inputs applied in cycle N determine prog_ctr after edge N+1.
- Reset values: state IDLE; stack empty (pointer 0); ras_overflow=0, ras_underflow=0; running=0, done=0; jump_en=1, abs_jump=0, target=0.
- Reset mid-operation: reset dominates every other input. The stack and flags are cleared on the same edge on which the program counter returns to 0.
- Push and pop never occur in the same cycle, because ret has priority over call.
- Stack pointer range is 0..RAS_DEPTH. The pointer never wraps; full means pointer == RAS_DEPTH.
- Call target arithmetic is relative to prog_ctr of the call cycle. The return address wraps: prog_ctr = 2^D−1 pushes 0.
- Sticky flags remain set until reset or start.

## Structure
- Package pc_ctrl_pkg:
  - state enum (IDLE, RUN, HALT)
  - default D
  - hold-encoding constant
- Sub-module pc_ras: LIFO with push, pop, top, full, and empty.
  - Parameters D and RAS_DEPTH.
  - Top-of-stack output is combinational from the array.
  - Overflow and underflow policy lives in pc_ctrl; pc_ras ignores illegal push/pop.
- pc_ctrl contains the FSM, the priority mux, and the sticky flags.

## Test plan
- Reset, idle 3 cycles, then start: PC stays 0 through idle, then counts 0,1,2,3 after start; running=1.
- Relative branch at PC=5 with br_target=12'hFFE (−2): next PC=3.
- Absolute branch at PC=4 with br_target=12'h100: next PC=0x100.
- Nested calls (call at PC=2 to 0x40, call at 0x41 to 0x80), then two rets: PC returns to 0x42, then 3.
- Five calls with RAS_DEPTH=4: ras_overflow=1 after the 5th call, and the 5th jump is still taken. Then one ret: PC = return address of the 4th call.
- ret with an empty stack at PC=7: ras_underflow=1 and done=1, and PC holds at 7.
- stall_req 2 cycles at PC=9 together with br_valid: PC stays 9, and the branch is ignored.
- halt_req at PC=6: PC holds at 6 and done=1. Then start: PC=0 and flags cleared.
- reset asserted mid-call-sequence: PC=0, state IDLE, stack empty on the next cycle.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared constants for the program-counter sequencer: FSM encodings,
// default widths and the hold command that freezes the program counter.
package pc_ctrl_pkg;

  localparam int unsigned D_DEFAULT         = 12;
  localparam int unsigned RAS_DEPTH_DEFAULT = 4;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
  localparam logic [ST_W-1:0] ST_HALT = 2'd2;

  // The program counter has no enable; a relative jump of 0 holds it.
  localparam logic HOLD_JUMP_EN  = 1'b1;
  localparam logic HOLD_ABS_JUMP = 1'b0;

endpackage

// File: rtl/pc_ras.sv
// Return-address LIFO. Illegal push (full) and pop (empty) are ignored;
// the caller owns the overflow/underflow policy.
module pc_ras
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned D         = D_DEFAULT,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned PW = $clog2(RAS_DEPTH + 1);

  logic [PW-1:0] ptr;
  logic [D-1:0]  mem [RAS_DEPTH];

  assign full  = (ptr == PW'(RAS_DEPTH));
  assign empty = (ptr == '0);
  assign top   = empty ? '0 : mem[AW'(ptr - PW'(1))];

  // Pointer counts live entries and saturates at 0..RAS_DEPTH.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[AW'(ptr)] <= push_data;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter sequencer: per-cycle jump controls for fetch, branch,
// call/return, stall and halt, with sticky stack-error flags.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned D         = D_DEFAULT,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D-1:0] prog_ctr,
  input  logic         stall_req,
  input  logic         br_valid,
  input  logic         br_abs,
  input  logic [D-1:0] br_target,
  input  logic         call,
  input  logic         ret,
  input  logic         halt_req,
  output logic         jump_en,
  output logic         abs_jump,
  output logic [D-1:0] target,
  output logic         running,
  output logic         done,
  output logic         ras_overflow,
  output logic         ras_underflow
);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_clear;
  logic            ras_full;
  logic            ras_empty;
  logic [D-1:0]    ras_top;
  logic            set_ovf;
  logic            set_unf;

  pc_ras #(
    .D         (D),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .clear     (ras_clear),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (prog_ctr + D'(1)),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Priority mux: halt > stall > ret > call > branch > sequential.
  always_comb begin
    jump_en   = HOLD_JUMP_EN;
    abs_jump  = HOLD_ABS_JUMP;
    target    = '0;
    state_nxt = state;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (state == ST_RUN) begin
      if (halt_req) begin
        state_nxt = ST_HALT;
      end else if (stall_req) begin
        state_nxt = ST_RUN;
      end else if (ret) begin
        if (!ras_empty) begin
          ras_pop  = 1'b1;
          abs_jump = 1'b1;
          target   = ras_top;
        end else begin
          set_unf   = 1'b1;
          state_nxt = ST_HALT;
        end
      end else if (call) begin
        ras_push = 1'b1;
        set_ovf  = ras_full;
        abs_jump = br_abs;
        target   = br_target;
      end else if (br_valid) begin
        abs_jump = br_abs;
        target   = br_target;
      end else begin
        jump_en = 1'b0;
      end
    end else if (start) begin
      abs_jump  = 1'b1;
      ras_clear = 1'b1;
      state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || ras_clear) begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      if (set_ovf) ras_overflow <= 1'b1;
      if (set_unf) ras_underflow <= 1'b1;
    end
  end

  assign running = (state == ST_RUN);
  assign done    = (state == ST_HALT);

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: a real program-counter register closes the loop and a
// queue-based model of the sequencing rules predicts every PC and output.
module tb_pc_ctrl;

  localparam int unsigned D     = 12;
  localparam int unsigned DEPTH = 4;
  localparam int MODE_IDLE = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_HALT = 2;

  logic         clk = 1'b0;
  logic         reset, start, stall_req, br_valid, br_abs, call, ret, halt_req;
  logic [D-1:0] br_target;
  logic [D-1:0] prog_ctr;
  logic         jump_en, abs_jump, running, done, ras_overflow, ras_underflow;
  logic [D-1:0] target;

  int           checks = 0;
  int           failures = 0;

  int           m_mode;
  logic [D-1:0] m_pc;
  logic [D-1:0] m_stack[$];
  bit           m_ovf, m_unf;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (reset)        prog_ctr <= '0;
    else if (jump_en) prog_ctr <= abs_jump ? target : prog_ctr + target;
    else              prog_ctr <= prog_ctr + D'(1);
  end

  pc_ctrl #(.D(D), .RAS_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .prog_ctr      (prog_ctr),
    .stall_req     (stall_req),
    .br_valid      (br_valid),
    .br_abs        (br_abs),
    .br_target     (br_target),
    .call          (call),
    .ret           (ret),
    .halt_req      (halt_req),
    .jump_en       (jump_en),
    .abs_jump      (abs_jump),
    .target        (target),
    .running       (running),
    .done          (done),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, clock, check PC.
  task automatic step(input bit rs, input bit st, input bit stl, input bit bv,
                      input bit ba, input logic [D-1:0] bt, input bit cl,
                      input bit rt, input bit hl);
    logic         ej, ea;
    logic [D-1:0] et, npc, ra;
    reset = rs; start = st; stall_req = stl; br_valid = bv; br_abs = ba;
    br_target = bt; call = cl; ret = rt; halt_req = hl;
    #1;
    chk("running", 32'(running), 32'(m_mode == MODE_RUN));
    chk("done", 32'(done), 32'(m_mode == MODE_HALT));
    chk("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
    chk("ras_underflow", 32'(ras_underflow), 32'(m_unf));
    ej = 1'b1; ea = 1'b0; et = '0; npc = m_pc;
    if (m_mode != MODE_RUN) begin
      if (st) begin
        ea = 1'b1; npc = '0; m_mode = MODE_RUN;
        m_stack.delete(); m_ovf = 0; m_unf = 0;
      end
    end else if (hl) begin
      m_mode = MODE_HALT;
    end else if (stl) begin
      npc = m_pc;
    end else if (rt) begin
      if (m_stack.size() > 0) begin
        ea = 1'b1; et = m_stack.pop_back(); npc = et;
      end else begin
        m_unf = 1; m_mode = MODE_HALT;
      end
    end else if (cl) begin
      ra = m_pc + 1'b1;
      if (m_stack.size() < DEPTH) m_stack.push_back(ra);
      else m_ovf = 1;
      ea = ba; et = bt; npc = ba ? bt : m_pc + bt;
    end else if (bv) begin
      ea = ba; et = bt; npc = ba ? bt : m_pc + bt;
    end else begin
      ej = 1'b0; npc = m_pc + 1'b1;
    end
    if (!rs) begin
      chk("jump_en", 32'(jump_en), 32'(ej));
      chk("abs_jump", 32'(abs_jump), 32'(ea));
      if (ej) chk("target", 32'(target), 32'(et));
    end else begin
      npc = '0; m_mode = MODE_IDLE; m_stack.delete(); m_ovf = 0; m_unf = 0;
    end
    m_pc = npc;
    @(posedge clk);
    #1;
    chk("prog_ctr", 32'(prog_ctr), 32'(m_pc));
  endtask

  task automatic s_seq(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, 0, 0, 0);
  endtask
  task automatic s_start();           step(0, 1, 0, 0, 0, '0, 0, 0, 0); endtask
  task automatic s_rst();             step(1, 0, 0, 0, 0, '0, 0, 0, 0); endtask
  task automatic s_br(input bit a, input logic [D-1:0] t);   step(0, 0, 0, 1, a, t, 0, 0, 0); endtask
  task automatic s_call(input bit a, input logic [D-1:0] t); step(0, 0, 0, 0, a, t, 1, 0, 0); endtask
  task automatic s_ret();             step(0, 0, 0, 0, 0, '0, 0, 1, 0); endtask

  initial begin
    m_mode = MODE_IDLE; m_pc = '0; m_ovf = 0; m_unf = 0;
    // Reset, idle, start, count.
    s_rst();
    chk("rst_jump_en", 32'(jump_en), 32'd1);
    chk("rst_target", 32'(target), 32'd0);
    s_seq(3);
    chk("idle_pc", 32'(prog_ctr), 32'd0);
    s_start();
    chk("start_pc", 32'(prog_ctr), 32'd0);
    s_seq(3);
    chk("count_pc", 32'(prog_ctr), 32'd3);
    chk("count_running", 32'(running), 32'd1);
    // Relative and absolute branches.
    s_seq(2);
    s_br(0, 12'hFFE);
    chk("rel_br_pc", 32'(prog_ctr), 32'h003);
    s_seq(1);
    s_br(1, 12'h100);
    chk("abs_br_pc", 32'(prog_ctr), 32'h100);
    // Nested calls and returns.
    s_br(1, 12'h002);
    s_call(1, 12'h040);
    s_seq(1);
    s_call(1, 12'h080);
    s_ret();
    chk("ret1_pc", 32'(prog_ctr), 32'h042);
    s_ret();
    chk("ret2_pc", 32'(prog_ctr), 32'h003);
    // Overflow: fifth call dropped but taken.
    s_call(1, 12'h010); s_call(1, 12'h020); s_call(1, 12'h030);
    s_call(1, 12'h040); s_call(1, 12'h050);
    chk("ovf_pc", 32'(prog_ctr), 32'h050);
    chk("ovf_flag", 32'(ras_overflow), 32'd1);
    s_ret();
    chk("ovf_ret_pc", 32'(prog_ctr), 32'h031);
    s_ret(); s_ret(); s_ret();
    chk("drain_pc", 32'(prog_ctr), 32'h004);
    // Return address wraps at the top of the address space.
    s_br(1, 12'hFFF);
    s_call(0, 12'h011);
    chk("wrap_call_pc", 32'(prog_ctr), 32'h010);
    s_ret();
    chk("wrap_ret_pc", 32'(prog_ctr), 32'h000);
    // Underflow at PC 7.
    s_br(1, 12'h007);
    s_ret();
    chk("unf_pc", 32'(prog_ctr), 32'h007);
    chk("unf_flag", 32'(ras_underflow), 32'd1);
    chk("unf_done", 32'(done), 32'd1);
    s_seq(2);
    chk("halt_hold_pc", 32'(prog_ctr), 32'h007);
    // Restart, stall with a branch at PC 9.
    s_start();
    chk("restart_unf", 32'(ras_underflow), 32'd0);
    s_seq(9);
    step(0, 0, 1, 1, 1, 12'h123, 0, 0, 0);
    step(0, 0, 1, 1, 1, 12'h123, 0, 0, 0);
    chk("stall_pc", 32'(prog_ctr), 32'h009);
    // Halt at PC 6, then start.
    s_br(1, 12'h006);
    step(0, 0, 0, 1, 1, 12'h055, 1, 0, 1);
    chk("halt_pc", 32'(prog_ctr), 32'h006);
    chk("halt_done", 32'(done), 32'd1);
    s_start();
    chk("halt_start_pc", 32'(prog_ctr), 32'h000);
    // Reset mid-call sequence clears the stack.
    s_call(1, 12'h020);
    s_call(1, 12'h030);
    step(1, 0, 0, 0, 1, 12'h040, 1, 0, 0);
    chk("midrst_pc", 32'(prog_ctr), 32'h000);
    chk("midrst_running", 32'(running), 32'd0);
    s_start();
    s_ret();
    chk("midrst_empty", 32'(ras_underflow), 32'd1);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(r == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0, 1'($urandom), D'($urandom),
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 39) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
